// File: rtl/instruction_fetcher_if.sv
// Handshake bundle between the instruction fetcher, the instruction queue,
// the memory controller and the commit-side redirect.
interface instruction_fetcher_if;
  logic        rdy;
  logic        clear;
  logic [31:0] clear_pc;
  logic        iq_full;
  logic        iq_inst_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_inst;

  modport master (
    input  rdy, clear, clear_pc, iq_full, mem_resp_valid, mem_resp_inst,
    output iq_inst_valid, iq_inst, iq_pc, mem_req_valid, mem_req_addr
  );

  modport slave (
    output rdy, clear, clear_pc, iq_full, mem_resp_valid, mem_resp_inst,
    input  iq_inst_valid, iq_inst, iq_pc, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/instruction_fetcher.sv
// Fetch front end: direct-mapped one-word-per-line I-cache lookup, miss refill
// from memory, and at most one (inst, pc) push per cycle into the queue.
module instruction_fetcher #(
  parameter int          ICACHE_IDX_W = 8,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  instruction_fetcher_if.master bus
);
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        iq_valid_q, iq_valid_d;
  logic [31:0] iq_inst_q, iq_inst_d;
  logic [31:0] iq_pc_q, iq_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;

  logic [LINES-1:0] line_valid_q;
  logic [TAG_W-1:0] line_tag_q  [LINES];
  logic [31:0]      line_data_q [LINES];

  logic [ICACHE_IDX_W-1:0] rd_idx_s;
  logic [ICACHE_IDX_W-1:0] wr_idx_s;
  logic [TAG_W-1:0]        rd_tag_s;
  logic                    hit_s;
  logic                    fill_s;

  assign rd_idx_s = pc_q[ICACHE_IDX_W+1:2];
  assign rd_tag_s = pc_q[31:ICACHE_IDX_W+2];
  assign wr_idx_s = req_addr_q[ICACHE_IDX_W+1:2];
  assign hit_s    = line_valid_q[rd_idx_s] && (line_tag_q[rd_idx_s] == rd_tag_s);
  // A response is written even when it coincides with clear; only the push is dropped.
  assign fill_s   = !rst && bus.rdy && (state_q == WAIT_MEM) && bus.mem_resp_valid;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      iq_valid_q  <= 1'b0;
      iq_inst_q   <= 32'h0;
      iq_pc_q     <= 32'h0;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      iq_valid_q  <= iq_valid_d;
      iq_inst_q   <= iq_inst_d;
      iq_pc_q     <= iq_pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end

  // Cache valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid_q <= '0;
    end else if (fill_s) begin
      line_valid_q[wr_idx_s] <= 1'b1;
    end
  end

  // Cache tag and data arrays
  always_ff @(posedge clk) begin
    if (fill_s) begin
      line_tag_q[wr_idx_s]  <= req_addr_q[31:ICACHE_IDX_W+2];
      line_data_q[wr_idx_s] <= bus.mem_resp_inst;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!bus.rdy) begin
      state_d = state_q;
    end else if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = (!bus.iq_full && !hit_s) ? WAIT_MEM : IDLE;
        WAIT_MEM: state_d = bus.mem_resp_valid ? IDLE : WAIT_MEM;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    pc_d        = pc_q;
    iq_valid_d  = iq_valid_q;
    iq_inst_d   = iq_inst_q;
    iq_pc_d     = iq_pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    if (!bus.rdy) begin
      pc_d = pc_q;
    end else if (bus.clear) begin
      pc_d        = bus.clear_pc;
      iq_valid_d  = 1'b0;
      req_valid_d = 1'b0;
    end else begin
      iq_valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.iq_full) begin
            iq_valid_d = 1'b0;
          end else if (hit_s) begin
            iq_valid_d = 1'b1;
            iq_inst_d  = line_data_q[rd_idx_s];
            iq_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
          end else begin
            req_valid_d = 1'b1;
            req_addr_d  = {pc_q[31:2], 2'b00};
          end
        end
        WAIT_MEM: begin
          if (!bus.mem_resp_valid) begin
            req_valid_d = req_valid_q;
          end else if (bus.iq_full) begin
            req_valid_d = 1'b0;
          end else begin
            req_valid_d = 1'b0;
            iq_valid_d  = 1'b1;
            iq_inst_d   = bus.mem_resp_inst;
            iq_pc_d     = pc_q;
            pc_d        = pc_q + 32'd4;
          end
        end
        default: begin
          req_valid_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.iq_inst_valid = iq_valid_q;
  assign bus.iq_inst       = iq_inst_q;
  assign bus.iq_pc         = iq_pc_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: a transaction-level model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_instruction_fetcher;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  instruction_fetcher_if bus();

  instruction_fetcher #(.ICACHE_IDX_W(8), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Memory image seen by the bench-side memory controller
  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return {a[15:0], 16'h1357};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_init = 1'b0;
  bit          m_wait;
  logic [31:0] m_pc, m_inst, m_ipc, m_addr;
  logic        m_valid, m_req;
  logic [31:0] c_word [int];   // index -> cached word address (pc >> 2)
  logic [31:0] c_data [int];

  task automatic m_push(input logic [31:0] inst);
    m_valid = 1'b1;
    m_inst  = inst;
    m_ipc   = m_pc;
    m_pc    = m_pc + 32'd4;
  endtask

  task automatic model_step();
    int i;
    if (rst) begin
      m_init = 1'b1; m_wait = 1'b0; m_pc = 32'h0;
      m_valid = 1'b0; m_inst = 32'h0; m_ipc = 32'h0; m_req = 1'b0; m_addr = 32'h0;
      c_word.delete(); c_data.delete();
    end else if (bus.rdy && bus.clear) begin
      if (m_wait && bus.mem_resp_valid) begin
        i = int'((m_addr >> 2) % 256);
        c_word[i] = m_addr >> 2; c_data[i] = bus.mem_resp_inst;
      end
      m_pc = bus.clear_pc; m_wait = 1'b0; m_valid = 1'b0; m_req = 1'b0;
    end else if (bus.rdy) begin
      m_valid = 1'b0;
      if (m_wait) begin
        if (bus.mem_resp_valid) begin
          i = int'((m_addr >> 2) % 256);
          c_word[i] = m_addr >> 2; c_data[i] = bus.mem_resp_inst;
          m_req = 1'b0; m_wait = 1'b0;
          if (!bus.iq_full) m_push(bus.mem_resp_inst);
        end
      end else if (!bus.iq_full) begin
        i = int'((m_pc >> 2) % 256);
        if (c_word.exists(i) && c_word[i] == (m_pc >> 2)) m_push(c_data[i]);
        else begin
          m_req = 1'b1; m_addr = m_pc & 32'hFFFF_FFFC; m_wait = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_init) begin
      check("iq_inst_valid", {31'h0, bus.iq_inst_valid}, {31'h0, m_valid});
      check("mem_req_valid", {31'h0, bus.mem_req_valid}, {31'h0, m_req});
      check("mem_req_addr", bus.mem_req_addr, m_addr);
      check("iq_inst", bus.iq_inst, m_inst);
      check("iq_pc", bus.iq_pc, m_ipc);
    end
  end

  // ---------------- stimulus ----------------
  int resp_lat = 3;
  int resp_cnt = 0;

  // One clock; then the bench memory controller decides its response for the next edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.rdy) begin
      if (bus.mem_resp_valid) begin
        bus.mem_resp_valid = 1'b0;
        resp_cnt = 0;
      end else if (bus.mem_req_valid) begin
        resp_cnt++;
        if (resp_cnt >= resp_lat) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_inst  = memw(bus.mem_req_addr);
        end
      end else begin
        resp_cnt = 0;
      end
    end
  endtask

  task automatic do_clear(input logic [31:0] pc);
    bus.clear = 1'b1; bus.clear_pc = pc;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] addr);
    int n = 0;
    do begin tick(); n++; end while (!bus.mem_req_valid && n < 20);
    check("req_seen", {31'h0, bus.mem_req_valid}, 32'h1);
    check("req_addr", bus.mem_req_addr, addr);
  endtask

  task automatic wait_push(input logic [31:0] pc, input logic [31:0] inst);
    int n = 0;
    do begin tick(); n++; end while (!bus.iq_inst_valid && n < 20);
    check("push_seen", {31'h0, bus.iq_inst_valid}, 32'h1);
    check("push_pc", bus.iq_pc, pc);
    check("push_inst", bus.iq_inst, inst);
  endtask

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b1; bus.clear = 1'b0; bus.clear_pc = 32'h0; bus.iq_full = 1'b0;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_inst = 32'h0;
    tick(); tick();
    check("rst_valid", {31'h0, bus.iq_inst_valid}, 32'h0);
    check("rst_req", {31'h0, bus.mem_req_valid}, 32'h0);
    check("rst_addr", bus.mem_req_addr, 32'h0);
    rst = 1'b0;

    // Cold start and sequential misses
    wait_req(32'h0);
    tick();
    check("req_held", bus.mem_req_addr, 32'h0);
    wait_push(32'h0, 32'h0000_0013);
    wait_req(32'h4);
    wait_push(32'h4, memw(32'h4));
    wait_push(32'h8, memw(32'h8));
    wait_push(32'hC, memw(32'hC));

    // Hit streaming
    do_clear(32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stream_valid", {31'h0, bus.iq_inst_valid}, 32'h1);
      check("stream_pc", bus.iq_pc, 32'(k * 4));
      check("stream_noreq", {31'h0, bus.mem_req_valid}, 32'h0);
    end

    // Clear mid-miss
    resp_lat = 6;
    do_clear(32'h20);
    wait_req(32'h20);
    tick();
    do_clear(32'h100);
    check("clr_req_drop", {31'h0, bus.mem_req_valid}, 32'h0);
    check("clr_no_push", {31'h0, bus.iq_inst_valid}, 32'h0);
    resp_lat = 2;
    wait_req(32'h100);
    wait_push(32'h100, memw(32'h100));

    // Backpressure during hits
    bus.iq_full = 1'b1;
    do_clear(32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("full_no_push", {31'h0, bus.iq_inst_valid}, 32'h0);
    end
    bus.iq_full = 1'b0;
    wait_push(32'h0, 32'h0000_0013);
    wait_push(32'h4, memw(32'h4));
    bus.iq_full = 1'b1;
    tick(); tick();
    check("bp_no_push", {31'h0, bus.iq_inst_valid}, 32'h0);
    bus.iq_full = 1'b0;
    wait_push(32'h8, memw(32'h8));
    wait_push(32'hC, memw(32'hC));

    // Response while full
    wait_req(32'h10);
    bus.iq_full = 1'b1;
    for (int k = 0; k < 10 && bus.mem_req_valid; k++) tick();
    check("rf_req_done", {31'h0, bus.mem_req_valid}, 32'h0);
    check("rf_no_push", {31'h0, bus.iq_inst_valid}, 32'h0);
    tick(); tick();
    bus.iq_full = 1'b0;
    wait_push(32'h10, memw(32'h10));

    // Conflict eviction
    do_clear(32'h0);
    wait_push(32'h0, 32'h0000_0013);
    do_clear(32'h400);
    wait_req(32'h400);
    wait_push(32'h400, memw(32'h400));
    do_clear(32'h0);
    wait_req(32'h0);
    wait_push(32'h0, 32'h0000_0013);

    // rdy freeze with a push on the outputs
    bus.rdy = 1'b0;
    tick(); tick();
    check("frz_valid", {31'h0, bus.iq_inst_valid}, 32'h1);
    check("frz_pc", bus.iq_pc, 32'h0);
    bus.rdy = 1'b1;
    wait_push(32'h4, memw(32'h4));

    // PC wrap
    do_clear(32'hFFFF_FFFC);
    wait_push(32'hFFFF_FFFC, memw(32'hFFFF_FFFC));
    wait_push(32'h0, 32'h0000_0013);

    // Reset mid-miss abandons the request and empties the cache
    do_clear(32'h200);
    wait_req(32'h200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_resp_valid = 1'b0;
    check("rst_mid_req", {31'h0, bus.mem_req_valid}, 32'h0);
    wait_req(32'h0);
    wait_push(32'h0, 32'h0000_0013);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
